// File: rtl/popcnt_frame_ctrl.sv
// Frame popcount controller: counts set bits of each accepted word and presents one
// saturating total per frame. Optional POPCNT_MASK_EN adds in_mask_i to gate counted bits.
module popcnt_frame_ctrl #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
`ifdef POPCNT_MASK_EN
  input  logic [DATA_W-1:0] in_mask_i,
`endif
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  out_count_o,
  output logic              out_sat_o,
  output logic              busy_o
);

  localparam int PC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [PC_W-1:0]   pc_reg;
  logic              pc_valid_reg;
  logic [CNT_W-1:0]  acc_reg;
  logic              sat_reg;

  logic [DATA_W-1:0] count_word;
  logic [PC_W-1:0]   word_pc;
  logic              accept;
  logic              handoff;
  logic [CNT_W:0]    acc_sum;
  logic              acc_ovf;

  // Bits that contribute to the count for the current input word.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_count_bit
`ifdef POPCNT_MASK_EN
      assign count_word[gi] = in_data_i[gi] & in_mask_i[gi];
`else
      assign count_word[gi] = in_data_i[gi];
`endif
    end
  endgenerate

  always_comb begin
    word_pc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      word_pc = word_pc + PC_W'(count_word[i]);
    end
  end

  assign accept  = in_valid_i & in_ready_o;
  assign handoff = out_valid_o & out_ready_i;

  // One extra bit catches overflow; a sticky saturated acc stays pinned at max.
  assign acc_sum = {1'b0, acc_reg} + (CNT_W + 1)'(pc_reg);
  assign acc_ovf = acc_sum[CNT_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_next = in_last_i ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i && in_last_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = OUT;
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_reg       <= '0;
      pc_valid_reg <= 1'b0;
      acc_reg      <= '0;
      sat_reg      <= 1'b0;
    end else begin
      pc_valid_reg <= accept;
      if (accept) begin
        pc_reg <= word_pc;
      end
      if (handoff) begin
        acc_reg <= '0;
        sat_reg <= 1'b0;
      end else if (pc_valid_reg) begin
        if (acc_ovf) begin
          acc_reg <= CNT_MAX;
          sat_reg <= 1'b1;
        end else begin
          acc_reg <= acc_sum[CNT_W-1:0];
        end
      end
    end
  end

  assign out_count_o = out_valid_o ? acc_reg : '0;
  assign out_sat_o   = out_valid_o & sat_reg;

endmodule

// File: tb/tb_popcnt_frame_ctrl.sv
// Directed plus randomized bench for popcnt_frame_ctrl; frame totals come from a
// queue-based reference that sums $countones per word and clips at the counter maximum.
module tb_popcnt_frame_ctrl;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;
  localparam int unsigned MAXC = (2 ** CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
`ifdef POPCNT_MASK_EN
  logic [DATA_W-1:0] in_mask_i;
`endif
  logic              in_last_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CNT_W-1:0]  out_count_o;
  logic              out_sat_o;
  logic              busy_o;

  logic [DATA_W-1:0] frame[$];
  logic [DATA_W-1:0] all1;
  int n_checks = 0;
  int n_errors = 0;

  popcnt_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
`ifdef POPCNT_MASK_EN
    .in_mask_i  (in_mask_i),
`endif
    .in_last_i  (in_last_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_count_o(out_count_o),
    .out_sat_o  (out_sat_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_sum();
    int unsigned s = 0;
    foreach (frame[i]) s += $countones(frame[i]);
    return s;
  endfunction

  // Drives the first n_send words of frame; returns at the negedge after the last acceptance.
  task automatic send_frame(input int n_send, input int gap);
    int t;
    for (int i = 0; i < n_send; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = frame[i];
      in_last_i  = (i == frame.size() - 1);
      t = 0;
      while (in_ready_o !== 1'b1 && t < 50) begin
        @(negedge clk_i);
        t++;
      end
      if (t >= 50) begin
        check("in_ready_timeout", 32'(in_ready_o), 1);
        in_valid_i = 1'b0;
        return;
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      if (i < n_send - 1) repeat (gap) @(negedge clk_i);
    end
  endtask

  // Called in the cycle after the last handshake; checks the 2-cycle latency and the total.
  task automatic expect_out(input int unsigned sum);
    int unsigned ec = (sum > MAXC) ? MAXC : sum;
    int unsigned es = (sum > MAXC) ? 1 : 0;
    check("drain_out_valid", 32'(out_valid_o), 0);
    check("drain_in_ready", 32'(in_ready_o), 0);
    check("drain_busy", 32'(busy_o), 1);
    @(negedge clk_i);
    check("out_valid", 32'(out_valid_o), 1);
    check("out_count", 32'(out_count_o), ec);
    check("out_sat", 32'(out_sat_o), es);
    check("out_in_ready", 32'(in_ready_o), 0);
  endtask

  task automatic handshake(input int bp, input int unsigned sum);
    int unsigned ec = (sum > MAXC) ? MAXC : sum;
    int unsigned es = (sum > MAXC) ? 1 : 0;
    out_ready_i = 1'b0;
    repeat (bp) begin
      @(negedge clk_i);
      check("hold_valid", 32'(out_valid_o), 1);
      check("hold_count", 32'(out_count_o), ec);
      check("hold_sat", 32'(out_sat_o), es);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("post_hs_valid", 32'(out_valid_o), 0);
    check("post_hs_in_ready", 32'(in_ready_o), 1);
    check("post_hs_busy", 32'(busy_o), 0);
    check("post_hs_count", 32'(out_count_o), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_o), 1);
    check({tag, "_out_valid"}, 32'(out_valid_o), 0);
    check({tag, "_out_count"}, 32'(out_count_o), 0);
    check({tag, "_out_sat"}, 32'(out_sat_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
  endtask

  initial begin
    int unsigned s;
    int bp;
    int len;
    all1        = '1;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b0;
`ifdef POPCNT_MASK_EN
    in_mask_i   = '1;
`endif
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    $display("step: reset released");

    frame = {};
    frame.push_back(all1);
    send_frame(1, 0);
    expect_out(128);
    handshake(0, 128);
    $display("step: single all-ones word -> 128");

    frame = {};
    frame.push_back(128'h1);
    frame.push_back(128'hFF);
    frame.push_back(128'h0);
    frame.push_back(all1);
    send_frame(4, 0);
    expect_out(137);
    handshake(0, 137);
    $display("step: four-word back-to-back frame -> 137");

    frame = {};
    frame.push_back(128'hF0F0);
    send_frame(1, 0);
    expect_out(8);
    in_valid_i = 1'b1;
    in_data_i  = 128'h3;
    in_last_i  = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check("bp_valid", 32'(out_valid_o), 1);
      check("bp_count", 32'(out_count_o), 8);
      check("bp_sat", 32'(out_sat_o), 0);
      check("bp_in_ready", 32'(in_ready_o), 0);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("bp_release_in_ready", 32'(in_ready_o), 1);
    check("bp_release_valid", 32'(out_valid_o), 0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    frame = {};
    frame.push_back(128'h3);
    expect_out(2);
    handshake(0, 2);
    $display("step: backpressure held 5 cycles, next frame accepted after handshake");

    frame = {};
    for (int i = 0; i < 513; i++) frame.push_back(all1);
    send_frame(513, 0);
    expect_out(ref_sum());
    handshake(2, ref_sum());
    frame = {};
    frame.push_back(128'h3);
    send_frame(1, 0);
    expect_out(2);
    handshake(0, 2);
    $display("step: 513 all-ones words saturate, next frame 0x3 -> 2");

    frame = {};
    frame.push_back(128'h1);
    frame.push_back(128'hFF);
    frame.push_back(128'h0);
    frame.push_back(all1);
    send_frame(4, 3);
    expect_out(137);
    handshake(1, 137);
    $display("step: four-word frame with 3-cycle gaps -> 137");

    send_frame(2, 0);
    check("midframe_busy", 32'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    frame = {};
    frame.push_back(128'hF);
    send_frame(1, 0);
    expect_out(4);
    handshake(0, 4);
    $display("step: mid-frame reset discards partial frame, 0xF -> 4");

    frame = {};
    frame.push_back(all1);
`ifdef POPCNT_MASK_EN
    in_mask_i = 128'hFF;
    send_frame(1, 0);
    in_mask_i = '1;
    expect_out(8);
    handshake(0, 8);
    $display("step: masked all-ones word -> 8");
`else
    send_frame(1, 0);
    expect_out(128);
    handshake(0, 128);
    $display("step: unmasked all-ones word -> 128");
`endif

    for (int f = 0; f < 10; f++) begin
      frame = {};
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        frame.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      bp = int'($urandom_range(0, 3));
      s = ref_sum();
      send_frame(len, int'($urandom_range(0, 2)));
      expect_out(s);
      handshake(bp, s);
      $display("step: random frame %0d len=%0d total=%0d bp=%0d", f, len, s, bp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
